// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter in front of a bank of configuration registers.
// One requester is granted per cycle; the bank is exposed as a flat bus.
module reg_bank_arbiter #(
   parameter int                     NUM_REQ     = 4,
   parameter int                     NUM_REGS    = 8,
   parameter int                     ADDR_WIDTH  = 3,
   parameter int                     WORD_WIDTH  = 32,
   parameter logic [WORD_WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           hold_i,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [NUM_REQ-1:0]             req_clear_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
   input  logic [NUM_REQ*WORD_WIDTH-1:0]  req_data_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic [NUM_REGS*WORD_WIDTH-1:0] bank_data_o,
   output logic                           grant_valid_o,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id_o,
   output logic                           addr_error_o,
   output logic [15:0]                    conflict_count_o
);

   localparam int                IDW        = $clog2(NUM_REQ);
   localparam logic [IDW:0]      NUM_REQ_X  = (IDW+1)'(NUM_REQ);
   localparam logic [ADDR_WIDTH:0] NUM_REGS_X = (ADDR_WIDTH+1)'(NUM_REGS);

   logic [IDW-1:0]        ptr_q, ptr_d;
   logic [IDW-1:0]        gnt_idx;
   logic                  gnt_found;
   logic [IDW:0]          cand;
   logic                  grant_en;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [WORD_WIDTH-1:0] sel_data;
   logic                  sel_clear;
   logic                  addr_ok;
   logic                  wr_en;
   logic                  multi_valid;
   logic                  grant_valid_q, grant_valid_d;
   logic [IDW-1:0]        grant_id_q, grant_id_d;
   logic                  addr_error_q, addr_error_d;
   logic [15:0]           conflict_q, conflict_d;

   // First valid requester scanning ptr, ptr+1, ... modulo NUM_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + (IDW+1)'(k);
         if (cand >= NUM_REQ_X) begin
            cand = cand - NUM_REQ_X;
         end
         if (!gnt_found && req_valid_i[cand[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IDW-1:0];
         end
      end
   end

   assign grant_en    = gnt_found && !hold_i && !rst_i;
   assign req_ready_o = grant_en ? (NUM_REQ'(1) << gnt_idx) : '0;

   assign sel_addr  = req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_data  = req_data_i[gnt_idx*WORD_WIDTH +: WORD_WIDTH];
   assign sel_clear = req_clear_i[gnt_idx];
   assign addr_ok   = {1'b0, sel_addr} < NUM_REGS_X;
   assign wr_en     = grant_en && addr_ok;

   // Two or more bits set: clearing the lowest set bit leaves something.
   assign multi_valid = |(req_valid_i & (req_valid_i - NUM_REQ'(1)));

   always_comb begin
      ptr_d         = ptr_q;
      grant_valid_d = grant_en;
      grant_id_d    = grant_id_q;
      addr_error_d  = grant_en && !addr_ok;
      conflict_d    = conflict_q;
      if (grant_en) begin
         ptr_d      = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
         grant_id_d = gnt_idx;
      end
      if (multi_valid && !hold_i && conflict_q != 16'hFFFF) begin
         conflict_d = conflict_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q         <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         addr_error_q  <= 1'b0;
         conflict_q    <= '0;
      end else begin
         ptr_q         <= ptr_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         addr_error_q  <= addr_error_d;
         conflict_q    <= conflict_d;
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [WORD_WIDTH-1:0] word_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            word_q <= RESET_VALUE;
         end else if (wr_en && sel_addr == ADDR_WIDTH'(gi)) begin
            word_q <= sel_clear ? RESET_VALUE : sel_data;
         end
      end
      assign bank_data_o[gi*WORD_WIDTH +: WORD_WIDTH] = word_q;
   end

   assign grant_valid_o    = grant_valid_q;
   assign grant_id_o       = grant_id_q;
   assign addr_error_o     = addr_error_q;
   assign conflict_count_o = conflict_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: 4 requesters, 6 registers (non power of two),
// distinctive reset value so clears and resets are distinguishable from zero data.
module tb_reg_bank_arbiter;

   localparam int          NR = 4;
   localparam int          NG = 6;
   localparam int          AW = 3;
   localparam int          WW = 32;
   localparam logic [31:0] RV = 32'h1234_5678;

   logic              clk = 1'b0;
   logic              rst;
   logic              hold;
   logic [NR-1:0]     valid;
   logic [NR-1:0]     clear;
   logic [NR*AW-1:0]  addr;
   logic [NR*WW-1:0]  data;
   logic [NR-1:0]     ready;
   logic [NG*WW-1:0]  bank;
   logic              gv;
   logic [1:0]        gid;
   logic              aerr;
   logic [15:0]       cc;

   int          tests_run    = 0;
   int          tests_failed = 0;
   bit          quiet        = 1'b0;
   logic [31:0] exp_bank [NG];
   logic [3:0]  exp_ready;
   logic [1:0]  exp_id;

   reg_bank_arbiter #(
      .NUM_REQ    (NR),
      .NUM_REGS   (NG),
      .ADDR_WIDTH (AW),
      .WORD_WIDTH (WW),
      .RESET_VALUE(RV)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .hold_i          (hold),
      .req_valid_i     (valid),
      .req_clear_i     (clear),
      .req_addr_i      (addr),
      .req_data_i      (data),
      .req_ready_o     (ready),
      .bank_data_o     (bank),
      .grant_valid_o   (gv),
      .grant_id_o      (gid),
      .addr_error_o    (aerr),
      .conflict_count_o(cc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (!quiet && gv)
         $display("[TB] t=%0t grant id=%0d addr_error=%0b conflicts=%0d", $time, gid, aerr, cc);
   endtask

   task automatic set_req(input int i, input logic v, input logic c,
                          input logic [AW-1:0] a, input logic [31:0] d);
      valid[i]         = v;
      clear[i]         = c;
      addr[i*AW +: AW] = a;
      data[i*WW +: WW] = d;
   endtask

   task automatic model_reset();
      for (int r = 0; r < NG; r++) exp_bank[r] = RV;
   endtask

   task automatic check_bank(input string tag);
      for (int r = 0; r < NG; r++)
         check($sformatf("%s_reg%0d", tag, r), {32'b0, bank[r*WW +: WW]}, {32'b0, exp_bank[r]});
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; valid = '0; clear = '0; addr = '0; data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_gv", gv, 0);
      check("rst_cc", cc, 0);
      check("rst_gid", gid, 0);
      check_bank("rst_bank");

      // Lone write from requester 1 moves ptr to 2.
      set_req(1, 1'b1, 1'b0, 3'd1, 32'hAAAA_0001);
      #1 check("solo_ready", ready, 4'b0010);
      step();
      valid = '0;
      exp_bank[1] = 32'hAAAA_0001;
      check_bank("solo_bank");
      check("solo_gid", gid, 1);

      // Reset asserted mid-cycle with all requesters valid.
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(i), 32'(i));
      #1 check("pre_rst_ready", ready, 4'b0100);
      #1 rst = 1'b1;
      #1 model_reset();
      check("rst_ready", ready, 0);
      check_bank("midrst_bank");
      check("midrst_gv", gv, 0);
      check("midrst_cc", cc, 0);
      step();
      check("rst_edge_cc", cc, 0);
      check("rst_edge_ready", ready, 0);
      check("rst_edge_gv", gv, 0);
      rst = 1'b0;
      #1 check("post_rst_ready", ready, 4'b0001);

      // Full contention round robin.
      for (int c = 0; c < 8; c++) begin
         exp_ready = 4'b0001 << (c % 4);
         exp_id    = 2'(c % 4);
         check("rr_ready", ready, exp_ready);
         step();
         check("rr_gid", gid, exp_id);
         check("rr_gv", gv, 1);
         exp_bank[c % 4] = 32'(c % 4);
      end
      check("rr_cc", cc, 8);
      check_bank("rr_bank");
      valid = '0;

      // Skip and wrap: move ptr to 2, then only requesters 1 and 3 valid.
      set_req(1, 1'b1, 1'b0, 3'd1, 32'd1);
      #1 check("skip_pre_ready", ready, 4'b0010);
      step();
      set_req(3, 1'b1, 1'b0, 3'd3, 32'd3);
      for (int c = 0; c < 4; c++) begin
         exp_ready = (c % 2 == 0) ? 4'b1000 : 4'b0010;
         exp_id    = (c % 2 == 0) ? 2'd3 : 2'd1;
         #1 check("skip_ready", ready, exp_ready);
         step();
         check("skip_gid", gid, exp_id);
      end
      valid = '0;
      check("skip_cc", cc, 12);

      // Write then clear of the same register on consecutive cycles (ptr = 2).
      set_req(0, 1'b1, 1'b0, 3'd5, 32'hA5A5_A5A5);
      #1 check("race_w_ready", ready, 4'b0001);
      step();
      valid[0] = 1'b0;
      exp_bank[5] = 32'hA5A5_A5A5;
      check("race_w_reg5", {32'b0, bank[5*WW +: WW]}, 64'hA5A5_A5A5);
      set_req(2, 1'b1, 1'b1, 3'd5, 32'hFFFF_FFFF);
      #1 check("race_c_ready", ready, 4'b0100);
      step();
      valid = '0;
      exp_bank[5] = RV;
      check_bank("race_bank");

      // Out-of-range addresses 6 and 7 (ptr = 3).
      set_req(3, 1'b1, 1'b0, 3'd6, 32'hBAD0_0006);
      #1 check("oor6_ready", ready, 4'b1000);
      step();
      check("oor6_err", aerr, 1);
      check("oor6_gid", gid, 3);
      set_req(3, 1'b1, 1'b0, 3'd7, 32'hBAD0_0007);
      #1 check("oor7_ready", ready, 4'b1000);
      step();
      check("oor7_err", aerr, 1);
      valid = '0;
      step();
      check("oor_err_clr", aerr, 0);
      check("oor_gv_clr", gv, 0);
      check_bank("oor_bank");

      // Hold with ptr = 2 and three requesters valid.
      set_req(1, 1'b1, 1'b0, 3'd1, 32'd1);
      step();
      set_req(0, 1'b1, 1'b0, 3'd0, 32'd0);
      set_req(2, 1'b1, 1'b0, 3'd2, 32'd2);
      hold = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1 check("hold_ready", ready, 0);
         step();
      end
      check("hold_cc", cc, 12);
      check("hold_gv", gv, 0);
      hold = 1'b0;
      #1 check("unhold_ready", ready, 4'b0100);
      step();
      check("unhold_gid", gid, 2);
      check("unhold_cc", cc, 13);
      valid = '0;

      // Saturation of the conflict counter.
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(i), 32'(i));
      quiet = 1'b1;
      repeat (65000) @(posedge clk);
      #1 check("sat_mid_cc", cc, 16'hFDF5);
      repeat (5000) @(posedge clk);
      #1 check("sat_cc", cc, 16'hFFFF);
      valid = '0;
      quiet = 1'b0;
      step();
      check("sat_hold_cc", cc, 16'hFFFF);
      check_bank("final_bank");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Round-robin write arbiter and controller for a bank of configuration registers shared by several requesters. Each requester presents a valid/ready write or clear request; the block grants one per cycle, drives the per-register clock-enable and clear, and exposes the whole bank as a flat bus. It sits between the control-plane masters (host config port, sequencers, debug) and the datapath's parameter registers.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- NUM_REGS, 8: registers in the bank, 1..256; need not be a power of two
- ADDR_WIDTH, 3: request address width; ≥ ceil(log2(NUM_REGS))
- WORD_WIDTH, 32: register width
- RESET_VALUE, 0: value every register takes on reset or clear
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- hold  in  1  when 1, no grants are issued
- req_valid  in  NUM_REQ  per-requester request valid
- req_clear  in  NUM_REQ  1 = clear the addressed register, 0 = write req_data
- req_addr  in  NUM_REQ*ADDR_WIDTH  register index; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*WORD_WIDTH  write data, same packing
- req_ready  out  NUM_REQ  one-hot or zero grant; combinational from req_valid, hold, and the pointer
- bank_data  out  NUM_REGS*WORD_WIDTH  register contents; register r at [r*WORD_WIDTH +: WORD_WIDTH]
- grant_valid  out  1  registered; 1 the cycle after any transfer
- grant_id  out  log2(NUM_REQ)  registered index of the last granted requester
- addr_error  out  1  registered one-cycle pulse when a granted address ≥ NUM_REGS
- conflict_count  out  16  saturating count of cycles with ≥2 valid requesters while not on hold

## Operation
- Transfer: requester i transfers on a cycle with req_valid[i] && req_ready[i]. Requesters must hold valid, addr, data, and clear stable until transfer.
- Arbitration: the priority pointer `ptr` has reset value 0. With hold = 0, grant goes to the first valid requester scanning ptr, ptr+1, … wrapping modulo NUM_REQ. At most one ready bit is high per cycle.
- Pointer update: after a transfer by requester g, ptr ← (g+1) mod NUM_REQ. Otherwise ptr is unchanged. Wrap from NUM_REQ-1 goes to 0.
- Write: the granted register's enable asserts for exactly that cycle. The register loads req_data, or RESET_VALUE when req_clear = 1. Clear takes priority over data.
- Address range: a granted address ≥ NUM_REGS is still acknowledged (ready = 1), but no register changes and addr_error pulses.
- Hold: forces req_ready = 0. ptr is frozen, registers hold, and conflict_count does not increment.
- Reset (asynchronous, any time, including mid-transfer) takes the following values:
  - all registers = RESET_VALUE
  - ptr = 0
  - grant_valid = 0, grant_id = 0, addr_error = 0, conflict_count = 0
  - a transfer in the reset cycle is lost
- Release of reset is synchronous to clock; the first grant can occur in the first cycle after release.
- conflict_count saturates at 16'hFFFF and never wraps.

## Timing
- req_ready is combinational in the same cycle as req_valid; there is no registered-ready bubble.
- Write latency is 1: data accepted at edge N is visible on bank_data after edge N, i.e., in cycle N+1.
- grant_valid, grant_id, and addr_error are updated at the same edge as the write.
- Sustained throughput is 1 write per cycle for the bank as a whole. Under full contention each requester gets 1 of every NUM_REQ cycles.
- Two requesters targeting the same register in consecutive cycles both land in grant order; the later write wins.
- No combinational path from req_data to bank_data.

## Test plan
- Reset values: assert reset mid-write with all four requesters valid → bank_data all RESET_VALUE, req_ready = 0 during reset, conflict_count = 0, first grant after release goes to requester 0.
- Round-robin fairness: all 4 valid continuously, each writing its own id to reg id, for 8 cycles → grant order 0,1,2,3,0,1,2,3; conflict_count = 8; reg0..3 = 0..3.
- Pointer skip and wrap: only requesters 1 and 3 valid, starting with ptr = 2 → grants 3,1,3,1; ptr wraps 0 after 3.
- Clear vs. write and the same-register race:
  - requester 0 writes reg5 = 0xA5A5A5A5
  - next cycle, requester 2 clears reg5 → reg5 = 0xA5A5A5A5 for one cycle, then RESET_VALUE
  - with NUM_REGS = 6, a write to addr 7 is acknowledged, addr_error = 1 for one cycle, and no register changes
- Hold: hold = 1 for 5 cycles with 3 valid requesters → no ready, ptr and conflict_count unchanged. Releasing hold resumes from the stored ptr.
- Saturation: force 70000 contention cycles → conflict_count stops at 0xFFFF.
